// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped 8N1 UART. A FIFO buffers each direction. The block adds sticky error flags
//   and a level interrupt.
// Ports: clk, rst (sync, active-high); sel/reg_addr/wdata/wstrb/rstrb/rdata form the register bus.
//   uart_rx is the async serial input; uart_tx is the serial output (idle high); irq is the level interrupt.
module uart_fifo_mmio #(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] wdata,
    input  logic        wstrb,
    input  logic        rstrb,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int unsigned DIV     = CLK_FREQ_HZ / BAUD_RATE;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
    localparam int          TAW     = $clog2(TX_DEPTH);
    localparam int          RAW     = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic rd, wr, rd_data, rd_status, wr_data, wr_ctrl;
    assign rd        = sel & rstrb;
    assign wr        = sel & wstrb;
    assign rd_data   = rd && (reg_addr == 2'd0);
    assign rd_status = rd && (reg_addr == 2'd1);
    assign wr_data   = wr && (reg_addr == 2'd0);
    assign wr_ctrl   = wr && (reg_addr == 2'd2);

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RAW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic         tx_empty, tx_full, tx_push, tx_pop, tx_idle;
    logic         rx_empty, rx_full, rx_push, rx_push_ok, rx_pop;

    state_e       tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]   tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic         tx_line_q, tx_line_d;
    logic [2:0]   rx_sync_q, rx_sync_d;
    logic         rx_s, rx_prev, frame_set;
    logic [2:0]   sticky_q, sticky_d;
    logic [1:0]   ctrl_q, ctrl_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         irq_q, irq_d;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q == {~tx_rp_q[TAW], tx_rp_q[TAW-1:0]});
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q == {~rx_rp_q[RAW], rx_rp_q[RAW-1:0]});
    assign tx_idle  = tx_empty && (tx_state_q == S_IDLE);

    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands
    assign tx_push    = wr_data & (~tx_full | tx_pop);
    assign rx_pop     = rd_data & ~rx_empty;
    assign rx_push_ok = rx_push & (~rx_full | rx_pop);

    // rx_sync_q: [0] first stage, [1] synchronised line, [2] previous synchronised value
    assign rx_s    = rx_sync_q[1];
    assign rx_prev = rx_sync_q[2];

    always_comb begin
        tx_wp_d   = tx_wp_q + (TAW+1)'(tx_push);
        tx_rp_d   = tx_rp_q + (TAW+1)'(tx_pop);
        rx_wp_d   = rx_wp_q + (RAW+1)'(rx_push_ok);
        rx_rp_d   = rx_rp_q + (RAW+1)'(rx_pop);
        rx_sync_d = {rx_sync_q[1:0], uart_rx};
    end

    // TX FSM: the pop and the entry to START share an edge; STOP chains straight into the next START
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                tx_pop   = ~tx_empty;
            end
            S_START: if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d = '0;
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end
            S_STOP: if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d   = '0;
                tx_pop     = ~tx_empty;
                tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_sh_d    = tx_mem[tx_rp_q[TAW-1:0]];
            tx_cnt_d   = '0;
            tx_state_d = S_START;
        end
        tx_line_d = 1'b1;
        if (tx_state_d == S_START) tx_line_d = 1'b0;
        else if (tx_state_d == S_DATA) tx_line_d = tx_sh_d[0];
    end

    // RX FSM: samples at mid-bit and re-checks the start bit to reject short glitches
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev & ~rx_s) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
            S_STOP: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = '0;
                rx_push    = rx_s;
                frame_set  = ~rx_s;
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Registers: status-read clear loses to an event in the same cycle
    always_comb begin
        sticky_d = (sticky_q & {3{~rd_status}})
                 | {wr_data & ~tx_push, frame_set, rx_push & ~rx_push_ok};
        ctrl_d   = wr_ctrl ? wdata[1:0] : ctrl_q;
        rdata_d  = rdata_q;
        if (rd) begin
            unique case (reg_addr)
                2'd0:    rdata_d = {23'b0, ~rx_empty,
                                    rx_empty ? 8'h00 : rx_mem[rx_rp_q[RAW-1:0]]};
                2'd1:    rdata_d = {18'b0, sticky_q, tx_idle, tx_full, ~rx_empty, 8'b0};
                2'd2:    rdata_d = {30'b0, ctrl_q};
                default: rdata_d = '0;
            endcase
        end
        irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= wdata[7:0];
        if (rx_push_ok) rx_mem[rx_wp_q[RAW-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_line_q  <= 1'b1;
            rx_sync_q  <= '1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            sticky_q   <= '0;
            ctrl_q     <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_line_q  <= tx_line_d;
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            sticky_q   <= sticky_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign uart_tx = tx_line_q;
    assign rdata   = rdata_q;
    assign irq     = irq_q;

endmodule
